echo_request_deserializer: RTL and testbench



---
 rtl/echo_request_deserializer.sv | 108 ++++++++++
 tb/tb_echo_request_deserializer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_request_deserializer.sv
// Rebuilds say(meth, v) calls from the host request word stream.
// Malformed or unknown messages are drained and counted.
module echo_request_deserializer #(
  parameter int unsigned SAY_METHOD_ID   = 0,
  parameter int unsigned SAY_PAYLOAD_LEN = 2,
  parameter int unsigned ERR_W           = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pipe_enq__ENA,
  input  logic [31:0]      pipe_enq_v,
  output logic             pipe_enq__RDY,
  output logic             say__ENA,
  output logic [31:0]      say_meth,
  output logic [31:0]      say_v,
  input  logic             say__RDY,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);

  typedef enum logic [2:0] {
    HDR, PAY0, PAY1, HOLD, DISCARD
  } state_t;

  localparam logic [15:0] SAY_ID  = 16'(SAY_METHOD_ID);
  localparam logic [15:0] SAY_LEN = 16'(SAY_PAYLOAD_LEN);

  state_t      state;
  state_t      hdr_state;
  logic [15:0] remaining;
  logic [15:0] hdr_id;
  logic [15:0] hdr_len;
  logic        hdr_say;
  logic        hdr_xfer;
  logic        wx;
  logic        sx;
  logic        err_sat;

  assign pipe_enq__RDY = !RST &&
    ((state == HOLD) ? say__RDY : 1'b1);
  assign wx      = pipe_enq__ENA && pipe_enq__RDY;
  assign sx      = say__ENA && say__RDY;
  assign busy    = (state != HDR);
  assign hdr_id  = pipe_enq_v[31:16];
  assign hdr_len = pipe_enq_v[15:0];
  assign hdr_say = (hdr_id == SAY_ID) && (hdr_len == SAY_LEN);
  assign err_sat = &err_count;

  // In HOLD a word can only move when the say transfer also happens,
  // so the header decode is shared between HDR and HOLD.
  assign hdr_xfer = wx && ((state == HDR) || (state == HOLD));

  always_comb begin
    hdr_state = DISCARD;
    if (hdr_say)
      hdr_state = PAY0;
    else if (hdr_len == 16'd0)
      hdr_state = HDR;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= HDR;
      say__ENA  <= 1'b0;
      say_meth  <= '0;
      say_v     <= '0;
      err_count <= '0;
      remaining <= '0;
    end else begin
      unique case (state)
        HDR, HOLD: begin
          if (state == HOLD && sx)
            say__ENA <= 1'b0;
          if (hdr_xfer) begin
            state     <= hdr_state;
            remaining <= hdr_len;
          end else if (state == HOLD && sx) begin
            state <= HDR;
          end
        end
        PAY0: begin
          if (wx) begin
            say_meth <= pipe_enq_v;
            state    <= PAY1;
          end
        end
        PAY1: begin
          if (wx) begin
            say_v    <= pipe_enq_v;
            say__ENA <= 1'b1;
            state    <= HOLD;
          end
        end
        DISCARD: begin
          if (wx) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1)
              state <= HDR;
          end
        end
        default: state <= HDR;
      endcase
      if (hdr_xfer && !hdr_say && !err_sat)
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_echo_request_deserializer.sv
// Bench for echo_request_deserializer: directed scenarios plus a
// randomized message stream checked against a message-level model.
module tb_echo_request_deserializer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        pipe_enq__ENA = 1'b0;
  logic [31:0] pipe_enq_v = '0;
  logic        pipe_enq__RDY;
  logic        say__ENA;
  logic [31:0] say_meth;
  logic [31:0] say_v;
  logic        say__RDY = 1'b0;
  logic [7:0]  err_count;
  logic        busy;

  echo_request_deserializer dut (
    .CLK(CLK),
    .RST(RST),
    .pipe_enq__ENA(pipe_enq__ENA),
    .pipe_enq_v(pipe_enq_v),
    .pipe_enq__RDY(pipe_enq__RDY),
    .say__ENA(say__ENA),
    .say_meth(say_meth),
    .say_v(say_v),
    .say__RDY(say__RDY),
    .err_count(err_count),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [63:0] obs[$];
  int          obs_cyc[$];
  int          cyc = 0;
  int          stab_err = 0;
  logic        pend = 1'b0;
  logic [63:0] pend_val = '0;
  bit          rnd_rdy = 1'b0;

  logic [31:0] words[$];
  logic [63:0] exp_q[$];
  int          exp_err;

  // Outputs observed mid-cycle; a transfer is ENA&&RDY seen here.
  always @(negedge CLK) begin
    cyc++;
    if (pend && (say__ENA !== 1'b1 || {say_meth, say_v} !== pend_val))
      stab_err++;
    if (say__ENA === 1'b1 && say__RDY === 1'b1) begin
      obs.push_back({say_meth, say_v});
      obs_cyc.push_back(cyc);
    end
    pend = (say__ENA === 1'b1) && !say__RDY && !RST;
    pend_val = {say_meth, say_v};
  end

  always @(posedge CLK) begin
    if (rnd_rdy) begin
      #1;
      say__RDY = ($urandom % 3) != 0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    bit acc = 1'b0;
    int n = 0;
    pipe_enq__ENA = 1'b1;
    pipe_enq_v = w;
    while (!acc && n < 100) begin
      @(negedge CLK);
      acc = pipe_enq__RDY;
      @(posedge CLK);
      #1;
      n++;
    end
    pipe_enq__ENA = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_word timeout word=%h", w);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    pipe_enq__ENA = 1'b0;
    cycles(2);
    RST = 1'b0;
    obs.delete();
    obs_cyc.delete();
    stab_err = 0;
  endtask

  // Message-level model: walk headers and skip by length.
  function automatic void model();
    int i = 0;
    logic [15:0] id;
    logic [15:0] len;
    exp_q.delete();
    exp_err = 0;
    while (i < words.size()) begin
      id = words[i][31:16];
      len = words[i][15:0];
      if (id == 16'd0 && len == 16'd2) begin
        exp_q.push_back({words[i+1], words[i+2]});
        i += 3;
      end else begin
        if (exp_err < 255) exp_err++;
        i += 1 + int'(len);
      end
    end
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    say__RDY = 1'b1;
    cycles(2);
    @(negedge CLK);
    checks++;
    if ({pipe_enq__RDY, say__ENA, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000",
               {pipe_enq__RDY, say__ENA, busy});
    end
    checks++;
    if ({say_meth, say_v, err_count} !== 72'd0) begin
      errors++;
      $display("FAIL reset_regs meth=%h v=%h err=%0d want 0",
               say_meth, say_v, err_count);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cycles(1);
    checks++;
    if (pipe_enq__RDY !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_rdy got=%b want=1", pipe_enq__RDY);
    end
  endtask

  task automatic test_basic();
    do_reset();
    say__RDY = 1'b1;
    send_word(32'h0000_0002);
    send_word(32'h0000_0007);
    send_word(32'h0000_002A);
    checks++;
    if ({say__ENA, say_meth, say_v} !== {1'b1, 32'd7, 32'd42}) begin
      errors++;
      $display("FAIL basic_out ena=%b meth=%0d v=%0d want 1/7/42",
               say__ENA, say_meth, say_v);
    end
    cycles(1);
    checks++;
    if (say__ENA !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle ena=%b want=0", say__ENA);
    end
    checks++;
    if (obs.size() != 1 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL basic_count xfers=%0d err=%0d want 1/0",
               obs.size(), err_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    say__RDY = 1'b0;
    send_word(32'h0000_0002);
    send_word(32'h0000_0007);
    send_word(32'h0000_002A);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({say__ENA, say_meth, say_v, pipe_enq__RDY} !==
          {1'b1, 32'd7, 32'd42, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d] ena=%b meth=%0d v=%0d rdy=%b want 1/7/42/0",
                 i, say__ENA, say_meth, say_v, pipe_enq__RDY);
      end
      cycles(1);
    end
    say__RDY = 1'b1;
    cycles(1);
    checks++;
    if (say__ENA !== 1'b0 || obs.size() != 1) begin
      errors++;
      $display("FAIL bp_release ena=%b xfers=%0d want 0/1",
               say__ENA, obs.size());
    end
    checks++;
    if (obs.size() == 1 && obs[0] !== {32'd7, 32'd42}) begin
      errors++;
      $display("FAIL bp_value got=%h want=%h", obs[0], {32'd7, 32'd42});
    end
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL bp_stable violations=%0d want 0", stab_err);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    logic [31:0] m[3];
    logic [31:0] v[3];
    do_reset();
    say__RDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m[i] = $urandom;
      v[i] = $urandom;
    end
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      send_word(32'h0000_0002);
      send_word(m[i]);
      send_word(v[i]);
    end
    t1 = cyc;
    cycles(2);
    checks++;
    if (t1 - t0 != 9) begin
      errors++;
      $display("FAIL b2b_cycles got=%0d want=9", t1 - t0);
    end
    checks++;
    if (obs.size() != 3) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=3", obs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== {m[i], v[i]}) begin
          errors++;
          $display("FAIL b2b_val[%0d] got=%h want=%h", i, obs[i], {m[i], v[i]});
        end
      end
      checks++;
      if (obs_cyc[1] - obs_cyc[0] != 3 || obs_cyc[2] - obs_cyc[1] != 3) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d,%0d want=3,3",
                 obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[1]);
      end
    end
  endtask

  task automatic test_unknown_id();
    do_reset();
    say__RDY = 1'b1;
    send_word(32'h0005_0003);
    repeat (3) send_word($urandom);
    send_word(32'h0000_0002);
    send_word(32'd1);
    send_word(32'd2);
    cycles(2);
    checks++;
    if (err_count !== 8'd1 || obs.size() != 1) begin
      errors++;
      $display("FAIL unk_count err=%0d xfers=%0d want 1/1",
               err_count, obs.size());
    end
    checks++;
    if (obs.size() == 1 && obs[0] !== {32'd1, 32'd2}) begin
      errors++;
      $display("FAIL unk_value got=%h want=%h", obs[0], {32'd1, 32'd2});
    end
  endtask

  task automatic test_wrong_len();
    do_reset();
    say__RDY = 1'b1;
    send_word(32'h0000_0003);
    repeat (3) send_word($urandom);
    send_word(32'h0000_0000);
    cycles(2);
    checks++;
    if (err_count !== 8'd2 || obs.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wronglen err=%0d xfers=%0d busy=%b want 2/0/0",
               err_count, obs.size(), busy);
    end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    say__RDY = 1'b1;
    repeat (300) send_word(32'h0000_0000);
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_err got=%0d want=255", err_count);
    end
    send_word(32'h0000_0002);
    send_word(32'h0000_0005);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL sat_midmsg_busy got=%b want=1", busy);
    end
    RST = 1'b1;
    cycles(1);
    checks++;
    if ({say__ENA, busy, err_count} !== 10'd0) begin
      errors++;
      $display("FAIL rst_mid ena=%b busy=%b err=%0d want 0/0/0",
               say__ENA, busy, err_count);
    end
    RST = 1'b0;
    cycles(3);
    checks++;
    if (obs.size() != 0 || say__ENA !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_say xfers=%0d ena=%b want 0/0",
               obs.size(), say__ENA);
    end
    send_word(32'h0000_0002);
    send_word(32'd11);
    send_word(32'd22);
    cycles(2);
    checks++;
    if (obs.size() != 1 || obs[0] !== {32'd11, 32'd22}) begin
      errors++;
      $display("FAIL rst_fresh xfers=%0d first=%h want 1/%h",
               obs.size(), obs.size() > 0 ? obs[0] : 64'd0,
               {32'd11, 32'd22});
    end
  endtask

  task automatic test_random();
    int len;
    logic [15:0] id;
    do_reset();
    words.delete();
    for (int k = 0; k < 40; k++) begin
      case ($urandom % 3)
        0: id = 16'd0;
        1: id = 16'd1;
        default: id = 16'd5;
      endcase
      len = ($urandom % 2 == 0) ? 2 : int'($urandom % 5);
      words.push_back({id, 16'(len)});
      for (int j = 0; j < len; j++) words.push_back($urandom);
    end
    model();
    rnd_rdy = 1'b1;
    foreach (words[i]) begin
      if ($urandom % 4 == 0) cycles(1 + int'($urandom % 3));
      send_word(words[i]);
    end
    cycles(1);
    rnd_rdy = 1'b0;
    say__RDY = 1'b1;
    cycles(5);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rnd_count got=%0d want=%0d", obs.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rnd_val[%0d] got=%h want=%h", i, obs[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (int'(err_count) != exp_err) begin
      errors++;
      $display("FAIL rnd_err got=%0d want=%0d", err_count, exp_err);
    end
    checks++;
    if (stab_err != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rnd_stable viol=%0d busy=%b want 0/0", stab_err, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_unknown_id();
    test_wrong_len();
    test_saturation_reset();
    repeat (3) test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
